conv1_drain: RTL and testbench

Sequencer and result reader for the first convolution layer. Starts a multi-channel conv pass, steers the channel index, and on each per-channel completion reads the 14x13 signed 24-bit feature map. Each map is reduced by 2x2 max-pool, ReLU, right-shift and unsigned saturation, then written as 8-bit activations into the next layer's activation memory over a simple write port.

---
 rtl/conv1_drain.sv | 193 +++++++++++++++++++
 tb/tb_conv1_drain.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/conv1_drain.sv
// Conv-layer-1 drain sequencer: runs CHAN conv passes and 2x2-max-pools / requantises each map into 8-bit activations.
// Optional build macro CONV1_DRAIN_ROUND_EN selects round-half-up requantisation instead of truncation.
module conv1_drain #(
  parameter int OUT_H = 14,
  parameter int OUT_W = 13,
  parameter int CHAN  = 10,
  parameter int SHIFT = 8,
  parameter int AW    = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     conv_trigger,
  output logic [3:0]               conv_chan,
  input  logic                     conv_valid,
  input  logic [3:0]               conv_chan_in,
  input  logic signed [23:0]       conv_buff [OUT_H][OUT_W],
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [7:0]               wr_data
);

  localparam int PH  = OUT_H / 2;
  localparam int PW  = OUT_W / 2;
  localparam int PIX = PH * PW;
  localparam int RW  = (PH > 1) ? $clog2(PH) : 1;
  localparam int CW  = (PW > 1) ? $clog2(PW) : 1;
  localparam int RIW = $clog2(OUT_H);
  localparam int CIW = $clog2(OUT_W);
  localparam logic [3:0]    LAST_CHAN = 4'(CHAN - 1);
  localparam logic [RW-1:0] LAST_R    = RW'(PH - 1);
  localparam logic [CW-1:0] LAST_C    = CW'(PW - 1);
  localparam logic [AW-1:0] PIX_A     = AW'(PIX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    POOL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [3:0]    chan_r, pool_chan_r, write_chan_s;
  logic [RW-1:0] r_r;
  logic [CW-1:0] c_r;
  logic [RIW-1:0] row0_s, row1_s;
  logic [CIW-1:0] col0_s, col1_s;
  logic          accept_s, write_s, last_pix_s, err_set_s;
  logic [7:0]    pix_s;
  logic          busy_r, done_r, err_r, trig_r, wr_en_r;
  logic [AW-1:0] wr_addr_r;
  logic [7:0]    wr_data_r;

  // Max of a 2x2 block, then ReLU, right-shift and unsigned 8-bit saturation.
  function automatic logic [7:0] pool_pix(input logic signed [23:0] p0, input logic signed [23:0] p1,
                                          input logic signed [23:0] p2, input logic signed [23:0] p3);
    logic signed [23:0] m01;
    logic signed [23:0] m23;
    logic signed [23:0] m;
    logic [24:0]        a;
    m01 = (p1 > p0) ? p1 : p0;
    m23 = (p3 > p2) ? p3 : p2;
    m   = (m23 > m01) ? m23 : m01;
    if (m < 24'sd0) begin
      a = 25'd0;
    end else begin
`ifdef CONV1_DRAIN_ROUND_EN
      a = ({1'b0, m} + (25'd1 << (SHIFT - 1))) >> SHIFT;
`else
      a = {1'b0, m} >> SHIFT;
`endif
    end
    return (a > 25'd255) ? 8'hFF : a[7:0];
  endfunction

  // Block selection and pooled pixel for the current write slot.
  always_comb begin
    row0_s = RIW'({r_r, 1'b0});
    row1_s = RIW'({r_r, 1'b1});
    col0_s = CIW'({c_r, 1'b0});
    col1_s = CIW'({c_r, 1'b1});
    pix_s  = pool_pix(conv_buff[row0_s][col0_s], conv_buff[row0_s][col1_s],
                      conv_buff[row1_s][col0_s], conv_buff[row1_s][col1_s]);
  end

  // Next-state logic; the accepting WAIT cycle already emits pixel 0 so writes start one cycle after conv_valid.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    write_s      = 1'b0;
    err_set_s    = 1'b0;
    last_pix_s   = (r_r == LAST_R) && (c_r == LAST_C);
    write_chan_s = (state_r == WAIT) ? chan_r : pool_chan_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = WAIT;
        else       state_s = IDLE;
      end
      WAIT: begin
        if (conv_valid && (conv_chan_in == chan_r)) begin
          accept_s = 1'b1;
          write_s  = 1'b1;
        end else if (conv_valid) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
      end
      POOL: begin
        write_s   = 1'b1;
        err_set_s = conv_valid;
      end
      DONE: begin
        err_set_s = conv_valid;
        state_s   = IDLE;
      end
      default: state_s = IDLE;
    endcase
    if (write_s && last_pix_s) begin
      state_s = (write_chan_s == LAST_CHAN) ? DONE : WAIT;
    end else if (write_s) begin
      state_s = POOL;
    end else begin
      state_s = state_s;
    end
  end

  // Channel index presented to the conv engine, advanced in the same cycle a completion is seen.
  always_comb begin
    if ((state_r == WAIT) && conv_valid && (chan_r < LAST_CHAN)) conv_chan = chan_r + 4'd1;
    else                                                          conv_chan = chan_r;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Control, channel tracking and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      trig_r      <= 1'b0;
      chan_r      <= 4'd0;
      pool_chan_r <= 4'd0;
      r_r         <= '0;
      c_r         <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 8'd0;
    end else begin
      trig_r  <= (state_r == IDLE) && start;
      done_r  <= (state_r == DONE);
      err_r   <= err_r | err_set_s;
      wr_en_r <= write_s;
      if ((state_r == IDLE) && start) begin
        busy_r <= 1'b1;
        chan_r <= 4'd0;
      end else if (state_r == DONE) begin
        busy_r <= 1'b0;
      end else if (accept_s && (chan_r < LAST_CHAN)) begin
        chan_r <= chan_r + 4'd1;
      end
      if (accept_s) pool_chan_r <= chan_r;
      if (write_s) begin
        wr_data_r <= pix_s;
        wr_addr_r <= accept_s ? AW'(chan_r) * PIX_A : wr_addr_r + {{(AW-1){1'b0}}, 1'b1};
        if (c_r == LAST_C) begin
          c_r <= '0;
          r_r <= (r_r == LAST_R) ? '0 : r_r + {{(RW-1){1'b0}}, 1'b1};
        end else begin
          c_r <= c_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign conv_trigger = trig_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;

endmodule

// File: tb/tb_conv1_drain.sv
// Directed bench for conv1_drain: table of per-channel pooling blocks plus hand sequences for protocol corners.
module tb_conv1_drain;
  logic              clk = 1'b0;
  logic              rst_n, start, busy, done, err, conv_trigger;
  logic [3:0]        conv_chan, conv_chan_in;
  logic              conv_valid;
  logic signed [23:0] conv_buff [14][13];
  logic              wr_en;
  logic [8:0]        wr_addr;
  logic [7:0]        wr_data;

  int checks = 0;
  int errors = 0;
  int nwr = 0;

  typedef struct {
    logic signed [23:0] a;
    logic signed [23:0] b;
    logic signed [23:0] c;
    logic signed [23:0] d;
    logic [7:0]         exp;
  } vec_t;
  vec_t tbl [10];

  conv1_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .conv_trigger(conv_trigger), .conv_chan(conv_chan), .conv_valid(conv_valid),
    .conv_chan_in(conv_chan_in), .conv_buff(conv_buff), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) nwr <= nwr + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_trig"}, {31'd0, conv_trigger}, 32'd0);
    chk({tag, "_chan"}, {28'd0, conv_chan}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {23'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
  endtask

  task automatic fill(input logic signed [23:0] v);
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 13; c++)
        conv_buff[r][c] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_trig", {31'd0, conv_trigger}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("trig_single", {31'd0, conv_trigger}, 32'd0);
  endtask

  task automatic run_channel(input int ch, input logic [7:0] exp0, input logic [7:0] bgexp,
                             input int dup_at, input int abort_at);
    conv_valid   = 1'b1;
    conv_chan_in = ch[3:0];
    #1;
    chk("conv_chan_next", {28'd0, conv_chan}, (ch < 9) ? ch + 1 : ch);
    @(negedge clk);
    conv_valid = 1'b0;
    for (int p = 0; p < 42; p++) begin
      if (p == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        return;
      end
      chk("wr_en", {31'd0, wr_en}, 32'd1);
      chk("wr_addr", {23'd0, wr_addr}, ch * 42 + p);
      chk("wr_data", {24'd0, wr_data}, (p == 0) ? {24'd0, exp0} : {24'd0, bgexp});
      if (p == dup_at) begin
        conv_valid   = 1'b1;
        conv_chan_in = 4'(ch + 1);
      end
      @(negedge clk);
      conv_valid = 1'b0;
      if (p == dup_at) chk("err_dup", {31'd0, err}, 32'd1);
    end
    chk("wr_en_end", {31'd0, wr_en}, 32'd0);
  endtask

  task automatic check_done();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_single", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n0;
    tbl[0] = '{a: 24'sh000100, b: 24'sh000100, c: 24'sh000100, d: 24'sh000100, exp: 8'd1};
    tbl[1] = '{a: -24'sd5,     b: 24'sh001234, c: 24'sh0000FF, d: -24'sd1,     exp: 8'h12};
    tbl[2] = '{a: -24'sh7FFFFF, b: -24'sh7FFFFF, c: -24'sh7FFFFF, d: -24'sh7FFFFF, exp: 8'd0};
    tbl[3] = '{a: 24'sh7FFFFF, b: 24'sh000000, c: 24'sh000000, d: 24'sh000000, exp: 8'hFF};
    tbl[5] = '{a: 24'sh000000, b: 24'sh000000, c: 24'sh010000, d: 24'sh000000, exp: 8'hFF};
    tbl[7] = '{a: -24'sd1,     b: -24'sd2,     c: -24'sd3,     d: 24'sh000200, exp: 8'd2};
    tbl[8] = '{a: 24'sh00007F, b: 24'sh000000, c: 24'sh000000, d: 24'sh000000, exp: 8'd0};
    tbl[9] = '{a: 24'sh0002FF, b: 24'sh0002FF, c: 24'sh0002FF, d: 24'sh000300, exp: 8'd3};
`ifdef CONV1_DRAIN_ROUND_EN
    tbl[4] = '{a: 24'sh000180, b: 24'sh000000, c: 24'sh000000, d: 24'sh000000, exp: 8'd2};
    tbl[6] = '{a: 24'sh0000FF, b: 24'sh000000, c: 24'sh000000, d: 24'sh000000, exp: 8'd1};
`else
    tbl[4] = '{a: 24'sh000180, b: 24'sh000000, c: 24'sh000000, d: 24'sh000000, exp: 8'd1};
    tbl[6] = '{a: 24'sh0000FF, b: 24'sh000000, c: 24'sh000000, d: 24'sh000000, exp: 8'd0};
`endif

    start = 1'b0; conv_valid = 1'b0; conv_chan_in = 4'd0; rst_n = 1'b0;
    fill(24'sh000100);
    @(negedge clk);
    do_reset();

    // Pass A: one block vector per channel; odd last column holds a huge value that pooling must drop.
    do_start();
    for (int ch = 0; ch < 10; ch++) begin
      fill(24'sh000100);
      for (int r = 0; r < 14; r++) conv_buff[r][12] = 24'sh7FFFFF;
      conv_buff[0][0] = tbl[ch].a; conv_buff[0][1] = tbl[ch].b;
      conv_buff[1][0] = tbl[ch].c; conv_buff[1][1] = tbl[ch].d;
      run_channel(ch, tbl[ch].exp, 8'd1, -1, -1);
      if (ch < 9) repeat (3) @(negedge clk);
    end
    check_done();
    chk("passA_writes", nwr, 32'd420);
    chk("passA_err", {31'd0, err}, 32'd0);

    // Pass B: negative then saturating maps, with a mismatched completion while chan 4 is expected.
    do_start();
    fill(-24'sh7FFFFF);
    for (int ch = 0; ch < 4; ch++) run_channel(ch, 8'd0, 8'd0, -1, -1);
    chk("pre_mismatch_err", {31'd0, err}, 32'd0);
    n0 = nwr;
    conv_valid = 1'b1; conv_chan_in = 4'd5;
    @(negedge clk);
    conv_valid = 1'b0;
    chk("mismatch_err", {31'd0, err}, 32'd1);
    chk("mismatch_no_wr", {31'd0, wr_en}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mismatch_wr_count", nwr, n0);
    chk("mismatch_busy", {31'd0, busy}, 32'd1);
    run_channel(4, 8'd0, 8'd0, -1, -1);
    fill(24'sh7FFFFF);
    for (int ch = 5; ch < 10; ch++) run_channel(ch, 8'hFF, 8'hFF, -1, -1);
    check_done();
    chk("passB_err_sticky", {31'd0, err}, 32'd1);

    // Pass C: duplicate completion during POOL, then reset in the middle of channel 2.
    do_reset();
    do_start();
    fill(24'sh000100);
    run_channel(0, 8'd1, 8'd1, 10, -1);
    run_channel(1, 8'd1, 8'd1, -1, -1);
    run_channel(2, 8'd1, 8'd1, -1, 20);
    n0 = nwr;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_abort_writes", nwr, n0);
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    chk("post_abort_err", {31'd0, err}, 32'd0);
    do_start();
    run_channel(0, 8'd1, 8'd1, -1, -1);
    chk("restart_writes", nwr, n0 + 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
